// File: rtl/vpg_pkg.sv
// Shared definitions for the video pattern generator: pattern mode encodings
// and the colour-bar table (1 bit per R,G,B, expanded to full scale on use).
package vpg_pkg;

    typedef enum logic [2:0] {
        VPG_BARS    = 3'd0,
        VPG_RAMP    = 3'd1,
        VPG_CHECKER = 3'd2,
        VPG_SOLID   = 3'd3,
        VPG_BORDER  = 3'd4
    } vpg_mode_e;

    localparam int NUM_BARS = 8;

    // Index 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster timing: h/v counters plus combinational DE, sync and
// frame-start decode of the current counter state (callers register them).
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          line_end,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    assign line_end = (int'(h) == H_TOTAL - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= (int'(v) == V_TOTAL - 1) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign de          = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign frame_start = (h == '0) && (v == '0);

    assign hsync = (int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC)
                   ? HS_POL : ~HS_POL;
    assign vsync = (int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC)
                   ? VS_POL : ~VS_POL;

endmodule

// File: rtl/video_pattern_gen.sv
// Free-running test-pattern source: per-frame mode/colour latch, bar counter,
// pattern mux, registered video outputs and completed-frame counter.
module video_pattern_gen
    import vpg_pkg::*;
#(
    parameter int BPC      = 8,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic [2:0]       MODE,
    input  logic [3*BPC-1:0] SOLID_RGB,
    output logic [3*BPC-1:0] VID_DATA,
    output logic             VID_HSYNC,
    output logic             VID_VSYNC,
    output logic             VID_DE,
    output logic             FRAME_START,
    output logic [15:0]      FRAME_CNT
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int BW      = $clog2(BAR_W + 1);

    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic             line_end, de, hsync, vsync, frame_start;
    logic [2:0]       mode_q, mode_eff;
    logic [3*BPC-1:0] solid_q, solid_eff, pixel;
    logic [BW-1:0]    bar_cnt;
    logic [2:0]       bar_idx;
    logic             started;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .clk(CLK), .rst_n(RSTn), .h(h), .v(v), .line_end(line_end), .de(de),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    function automatic logic [3*BPC-1:0] expand_rgb(input logic [2:0] rgb);
        return {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
    endfunction

    // Pixel (0,0) already uses the values being latched on the same edge.
    assign mode_eff  = frame_start ? MODE : mode_q;
    assign solid_eff = frame_start ? SOLID_RGB : solid_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q    <= '0;
            solid_q   <= '0;
            started   <= 1'b0;
            FRAME_CNT <= '0;
        end else if (frame_start) begin
            mode_q  <= MODE;
            solid_q <= SOLID_RGB;
            started <= 1'b1;
            if (started) FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

    // Bar index tracks h without a divider; the last bar absorbs the remainder.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (line_end) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (int'(bar_cnt) == BAR_W - 1) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_cnt <= bar_cnt + BW'(1);
        end
    end

    // NOTE: pixel gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pixel = '0;
        case (mode_eff)
            VPG_BARS:    pixel = expand_rgb(BAR_RGB[bar_idx]);
            VPG_RAMP:    pixel = {3{BPC'(h)}};
            VPG_CHECKER: pixel = (((int'(h) ^ int'(v)) & 32) != 0) ? '1 : '0;
            VPG_SOLID:   pixel = solid_eff;
            VPG_BORDER:  pixel = (h == '0 || int'(h) == H_ACTIVE - 1 ||
                                  v == '0 || int'(v) == V_ACTIVE - 1) ? '1 : '0;
            default:     pixel = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            VID_DATA    <= '0;
            VID_DE      <= 1'b0;
            VID_HSYNC   <= ~HS_POL;
            VID_VSYNC   <= ~VS_POL;
            FRAME_START <= 1'b0;
        end else begin
            VID_DATA    <= (de && ENABLE) ? pixel : '0;
            VID_DE      <= de;
            VID_HSYNC   <= hsync;
            VID_VSYNC   <= vsync;
            FRAME_START <= frame_start;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench: the driver pushes the expected output of every clock edge,
// a monitor pops and compares; a second instance covers the wide checkerboard.
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4,  VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;

    localparam int HA_B = 128, VA_B = 40;
    localparam int HT_B = HA_B + 6;

    typedef struct packed {
        logic [23:0] data;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_b = 1'b0;
    logic        enable = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [23:0] solid = 24'h0;
    logic [23:0] vid_data, vid_data_b;
    logic        hs, vs, de, fs, hs_b, vs_b, de_b, fs_b;
    logic [15:0] fcnt, fcnt_b;

    int   n_cmp = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    video_pattern_gen #(
        .BPC(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .CLK(clk), .RSTn(rst_n), .ENABLE(enable), .MODE(mode), .SOLID_RGB(solid),
        .VID_DATA(vid_data), .VID_HSYNC(hs), .VID_VSYNC(vs), .VID_DE(de),
        .FRAME_START(fs), .FRAME_CNT(fcnt)
    );

    video_pattern_gen #(
        .BPC(8), .H_ACTIVE(HA_B), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(VA_B), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .CLK(clk), .RSTn(rst_b), .ENABLE(1'b1), .MODE(3'd2), .SOLID_RGB(24'h0),
        .VID_DATA(vid_data_b), .VID_HSYNC(hs_b), .VID_VSYNC(vs_b), .VID_DE(de_b),
        .FRAME_START(fs_b), .FRAME_CNT(fcnt_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = '{data: vid_data, de: de, hs: hs, vs: vs, fs: fs, cnt: fcnt};
    assign obs_b = '{data: vid_data_b, de: de_b, hs: hs_b, vs: vs_b, fs: fs_b, cnt: fcnt_b};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference pixel: plain arithmetic straight from the raster and pattern rules.
    function automatic obs_t ref_px(input int ha, hfp, hsy, va, vfp, vsy, h, v,
                                    input logic [2:0] m, input logic [23:0] sol,
                                    input logic en);
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        obs_t        o;
        logic [23:0] pat;
        int          bi;
        o   = '0;
        pat = '0;
        o.de = (h < ha) && (v < va);
        o.hs = (h >= ha + hfp) && (h < ha + hfp + hsy);
        o.vs = (v >= va + vfp) && (v < va + vfp + vsy);
        case (m)
            3'd0: begin
                bi = h / (ha / 8);
                if (bi > 7) bi = 7;
                pat = bars[bi];
            end
            3'd1: pat = {3{8'(h % 256)}};
            3'd2: pat = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            3'd3: pat = sol;
            3'd4: pat = (h == 0 || h == ha - 1 || v == 0 || v == va - 1) ? 24'hFFFFFF : 24'h0;
            default: pat = 24'h0;
        endcase
        o.data = (o.de && en) ? pat : 24'h0;
        return o;
    endfunction

    // Model state: edges since reset release, frames started, latched mode/colour.
    int          t = 0;
    int          frames = 0;
    logic [2:0]  mode_m = 3'd0;
    logic [23:0] solid_m = 24'h0;

    function automatic int cur_h();
        return t % HT;
    endfunction

    function automatic int cur_v();
        return (t / HT) % VT;
    endfunction

    // Called at a negedge with this cycle's inputs already driven.
    task automatic step();
        obs_t e;
        int   h, v;
        h = cur_h();
        v = cur_v();
        if (h == 0 && v == 0) begin
            mode_m  = mode;
            solid_m = solid;
            frames++;
        end
        e     = ref_px(HA, HFP, HSY, VA, VFP, VSY, h, v, mode_m, solid_m, enable);
        e.fs  = (h == 0 && v == 0);
        e.cnt = 16'(frames - 1);
        exp_q.push_back(e);
        t++;
        @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        obs_t r;
        r = '0;
        check(name, 64'(obs_a), 64'(r));
    endtask

    initial begin : monitor
        obs_t e;
        int   idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("edge%0d", idx), 64'(obs_a), 64'(e));
                idx++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int f, h, v;
        solid = $urandom;
        repeat (3) @(negedge clk);
        check_reset("reset_initial");
        rst_n = 1'b1;

        for (int c = 0; c < 11 * FT; c++) begin
            f = t / FT;
            h = cur_h();
            v = cur_v();
            if (h == 0 && v == 0) begin
                case (f)
                    0, 1, 2: mode = 3'd0;
                    4: mode = 3'd1;
                    5: mode = 3'd2;
                    6: mode = 3'd4;
                    7: mode = 3'($urandom_range(5, 7));
                    default: ;
                endcase
            end
            if (f == 2 && h == 5 && v == 1) begin
                mode  = 3'd3;
                solid = 24'h123456;
            end
            enable = !(f == 4 && h == 9 && v == 2);
            if (f >= 8) begin
                mode   = 3'($urandom_range(0, 7));
                solid  = $urandom;
                enable = ($urandom_range(0, 7) != 0);
            end
            step();
        end

        // Async reset mid-frame at (7,2), held over three clock edges.
        while (!(cur_h() == 7 && cur_v() == 2)) step();
        #1 rst_n = 1'b0;
        #1 check_reset("reset_async");
        repeat (3) @(posedge clk);
        #1 check_reset("reset_held");
        @(negedge clk);
        rst_n   = 1'b1;
        t       = 0;
        frames  = 0;
        mode_m  = 3'd0;
        solid_m = 24'h0;
        for (int c = 0; c < 2 * FT; c++) begin
            if (cur_h() == 0 && cur_v() == 0) begin
                mode  = 3'($urandom_range(0, 4));
                solid = $urandom;
            end
            enable = 1'b1;
            step();
        end

        // Wide instance: checkerboard over the first 33 lines.
        rst_b = 1'b1;
        for (int k = 0; k <= 32 * HT_B + 32; k++) begin
            obs_t e;
            @(posedge clk);
            #1;
            h     = k % HT_B;
            v     = k / HT_B;
            e     = ref_px(HA_B, 2, 2, VA_B, 1, 1, h, v, 3'd2, 24'h0, 1'b1);
            e.fs  = (k == 0);
            e.cnt = 16'd0;
            check($sformatf("chk_b(%0d,%0d)", h, v), 64'(obs_b), 64'(e));
            if (k == 32) check("chk_pixel_32_0", 64'(vid_data_b), 64'h00FFFFFF);
            if (k == 32 * HT_B + 32) check("chk_pixel_32_32", 64'(vid_data_b), 64'h0);
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
